// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Default geometry, derived address-field widths and the refill FSM states.
package icache_pkg;

    localparam int NUM_LINES_DEF  = 64;
    localparam int LINE_WORDS_DEF = 4;

    localparam int OB_DEF    = $clog2(LINE_WORDS_DEF) + 2;
    localparam int IDX_W_DEF = $clog2(NUM_LINES_DEF);
    localparam int TAG_W_DEF = 32 - OB_DEF - IDX_W_DEF;

    localparam logic [31:0] RESET_ADDR = 32'hBFC00000;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } refill_state_e;

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: latches the missing line base, drives the memory
// request and steps through the beats, telling the arrays which word to write.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   lookup_miss,
    input  logic [31-($clog2(LINE_WORDS)+2):0]     line_base,
    input  logic                                   mem_valid,
    output logic                                   busy,
    output logic                                   mem_req,
    output logic [31:0]                            mem_addr,
    output logic                                   wr_en,
    output logic [$clog2(LINE_WORDS)-1:0]          wr_word,
    output logic                                   line_done
);

    localparam int WW = $clog2(LINE_WORDS);
    localparam int OB = WW + 2;

    refill_state_e     state_q, state_d;
    logic [WW-1:0]     cnt_q, cnt_d;
    logic [31-OB:0]    base_q, base_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wr_en     = 1'b0;
        line_done = 1'b0;
        if (state_q == IDLE) begin
            if (lookup_miss) begin
                base_d  = line_base;
                cnt_d   = '0;
                state_d = REFILL;
            end
        end else begin
            if (mem_valid) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WW'(LINE_WORDS - 1)) begin
                    line_done = 1'b1;
                    state_d   = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    assign busy     = (state_q == REFILL);
    assign mem_req  = busy;
    assign mem_addr = {base_q, {OB{1'b0}}};
    assign wr_word  = cnt_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hit lookup over
// valid/tag/data arrays, with whole-line refill handled by icache_refill_fsm.
module icache_dm
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = NUM_LINES_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_address_2IM,
    output logic [31:0] Instr1_fIM,
    output logic        miss,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Valid,
    input  logic [31:0] Mem_Data
);

    localparam int WW = $clog2(LINE_WORDS);
    localparam int OB = WW + 2;
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 32 - OB - IW;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [TW-1:0]        tag_d  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
    logic [31:0]          data_d [NUM_LINES][LINE_WORDS];

    logic [IW-1:0] fetch_idx, ref_idx;
    logic [TW-1:0] fetch_tag, ref_tag;
    logic [WW-1:0] fetch_word, wr_word;
    logic          line_match, hit, busy, wr_en, line_done;
    logic          unused_addr_bits;

    assign fetch_word = Instr_address_2IM[OB-1:2];
    assign fetch_idx  = Instr_address_2IM[OB+IW-1:OB];
    assign fetch_tag  = Instr_address_2IM[31:OB+IW];
    assign unused_addr_bits = ^Instr_address_2IM[1:0];

    // The refill target comes from the latched base, not the live fetch address.
    assign ref_idx = Mem_Addr[OB+IW-1:OB];
    assign ref_tag = Mem_Addr[31:OB+IW];

    assign line_match = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign hit        = !busy && line_match;
    assign miss       = !hit;
    assign Instr1_fIM = hit ? data_q[fetch_idx][fetch_word] : 32'h0;

    icache_refill_fsm #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk         (CLK),
        .reset       (RESET),
        .lookup_miss (!line_match),
        .line_base   (Instr_address_2IM[31:OB]),
        .mem_valid   (Mem_Valid),
        .busy        (busy),
        .mem_req     (Mem_Req),
        .mem_addr    (Mem_Addr),
        .wr_en       (wr_en),
        .wr_word     (wr_word),
        .line_done   (line_done)
    );

    // The line being refilled stays invalid until its last beat lands.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (busy) begin
            valid_d[ref_idx] = line_done;
            if (wr_en) begin
                data_d[ref_idx][wr_word] = Mem_Data;
            end
            if (line_done) begin
                tag_d[ref_idx] = ref_tag;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios then random traffic,
// all checked against a line-address-level reference model of the cache.
module tb_icache_dm;
    import icache_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Instr_address_2IM = 32'h0;
    logic [31:0] Instr1_fIM;
    logic        miss;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Valid = 1'b0;
    logic [31:0] Mem_Data = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each line remembers the full base address it holds.
    bit          m_valid [64];
    logic [31:0] m_base  [64];
    logic [31:0] m_words [64][4];
    bit          m_refill;
    logic [31:0] m_addr;
    logic [31:0] m_beats [$];

    icache_dm dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr_address_2IM (Instr_address_2IM),
        .Instr1_fIM        (Instr1_fIM),
        .miss              (miss),
        .Mem_Req           (Mem_Req),
        .Mem_Addr          (Mem_Addr),
        .Mem_Valid         (Mem_Valid),
        .Mem_Data          (Mem_Data)
    );

    always #5 CLK = ~CLK;

    function automatic int lineOf(logic [31:0] a);
        return int'((a / 32'd16) % 32'd64);
    endfunction

    function automatic bit modelHit(logic [31:0] a);
        int idx = lineOf(a);
        return !m_refill && m_valid[idx] && (m_base[idx] == (a & ~32'hF));
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_refill = 1'b0;
        m_addr   = 32'h0;
        m_beats.delete();
    endtask

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit h = modelHit(Instr_address_2IM);
        logic [31:0] exp_instr;
        exp_instr = h ? m_words[lineOf(Instr_address_2IM)][(Instr_address_2IM / 4) % 4] : 32'h0;
        compare("miss", {31'h0, miss}, {31'h0, !h});
        compare("instr", Instr1_fIM, exp_instr);
        compare("mem_req", {31'h0, Mem_Req}, {31'h0, m_refill});
        compare("mem_addr", Mem_Addr, m_addr);
    endtask

    task automatic modelStep(input logic [31:0] a, input logic v, input logic [31:0] d, input logic r);
        if (r) begin
            modelReset();
        end else if (!m_refill) begin
            if (!modelHit(a)) begin
                m_refill = 1'b1;
                m_addr   = a & ~32'hF;
                m_beats.delete();
            end
        end else if (v) begin
            m_beats.push_back(d);
            if (m_beats.size() == 4) begin
                int idx = lineOf(m_addr);
                m_valid[idx] = 1'b1;
                m_base[idx]  = m_addr;
                for (int i = 0; i < 4; i++) m_words[idx][i] = m_beats[i];
                m_refill = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic v, input logic [31:0] d, input logic r);
        Instr_address_2IM = a;
        Mem_Valid         = v;
        Mem_Data          = d;
        RESET             = r;
        #2;
        checkOutput();
        @(posedge CLK);
        modelStep(a, v, d, r);
        #1;
    endtask

    task automatic step(input logic [31:0] a, input logic v, input logic [31:0] d);
        applyStimulus(a, v, d, 1'b0);
    endtask

    task automatic refillBeats(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) step(a, 1'b1, $urandom);
    endtask

    initial begin
        logic [31:0] pool [3];
        logic [31:0] ra;
        pool[0] = RESET_ADDR;
        pool[1] = 32'h0040_0000;
        pool[2] = 32'h0000_0000;

        $display("[TB] reset");
        repeat (2) @(posedge CLK);
        modelReset();
        #1;

        $display("[TB] cold miss and first refill");
        step(RESET_ADDR, 1'b0, 32'h0);
        step(RESET_ADDR, 1'b1, 32'h11);
        step(RESET_ADDR, 1'b1, 32'h22);
        step(RESET_ADDR, 1'b1, 32'h33);
        step(RESET_ADDR, 1'b1, 32'h44);
        step(RESET_ADDR, 1'b0, 32'h0);
        compare("first_hit_word", Instr1_fIM, 32'h11);

        $display("[TB] sequential hits, stray Mem_Valid in IDLE");
        step(RESET_ADDR + 32'h4, 1'b1, 32'hDEAD_BEEF);
        step(RESET_ADDR + 32'h8, 1'b0, 32'h0);
        step(RESET_ADDR + 32'hC, 1'b0, 32'h0);
        compare("seq_hit_word", Instr1_fIM, 32'h44);

        $display("[TB] conflict on index 0");
        step(32'hBFC0_0400, 1'b0, 32'h0);
        refillBeats(32'hBFC0_0400, 4);
        step(32'hBFC0_0404, 1'b0, 32'h0);
        step(RESET_ADDR, 1'b0, 32'h0);
        refillBeats(RESET_ADDR, 4);
        step(RESET_ADDR, 1'b0, 32'h0);

        $display("[TB] gapped Mem_Valid");
        step(32'h0000_0020, 1'b0, 32'h0);
        step(32'h0000_0020, 1'b1, 32'hA0);
        step(32'h0000_0020, 1'b0, 32'h0);
        step(32'h0000_0020, 1'b0, 32'h0);
        step(32'h0000_0020, 1'b1, 32'hA1);
        step(32'h0000_0020, 1'b1, 32'hA2);
        step(32'h0000_0020, 1'b0, 32'h0);
        step(32'h0000_002C, 1'b1, 32'hA3);
        step(32'h0000_002C, 1'b0, 32'h0);
        compare("gap_last_word", Instr1_fIM, 32'hA3);

        $display("[TB] reset mid-refill");
        step(32'hBFC0_0400, 1'b0, 32'h0);
        refillBeats(32'hBFC0_0400, 2);
        applyStimulus(32'hBFC0_0400, 1'b1, 32'h55, 1'b1);
        step(RESET_ADDR, 1'b1, 32'h66);

        $display("[TB] address switch mid-refill");
        refillBeats(RESET_ADDR, 2);
        refillBeats(32'h0040_0010, 2);
        step(32'h0040_0010, 1'b0, 32'h0);
        step(32'h0040_0010, 1'b0, 32'h0);
        refillBeats(32'h0040_0014, 4);
        step(32'h0040_0014, 1'b0, 32'h0);
        step(RESET_ADDR + 32'h8, 1'b0, 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            ra = pool[$urandom_range(2, 0)] + 32'($urandom_range(3, 0)) * 32'd16
                 + 32'($urandom_range(3, 0)) * 32'd4 + 32'($urandom_range(3, 0));
            applyStimulus(ra, ($urandom_range(9, 0) < 6), $urandom, ($urandom_range(99, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
